// File: rtl/ctr_seq_encoder_pkg.sv
// Shared types and default command codes for the ctr line encoder.
package ctr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_RES = 2'd0,
    CMD_TBM = 2'd1,
    CMD_TRG = 2'd2,
    CMD_CAL = 2'd3
  } cmd_e;

  localparam int         DEF_SYM_LEN  = 3;
  localparam logic [2:0] DEF_CODE_CAL = 3'b100;
  localparam logic [2:0] DEF_CODE_TRG = 3'b110;
  localparam logic [2:0] DEF_CODE_RES = 3'b111;
  localparam logic [2:0] DEF_CODE_TBM = 3'b101;

endpackage

// File: rtl/ctr_seq_encoder_if.sv
// Request/status bundle between the command source and the ctr encoder.
interface ctr_seq_encoder_if #(
  parameter int CNT_W = 16
);
  logic             sync;
  logic             cal;
  logic             trg;
  logic             res_roc;
  logic             res_tbm;
  logic             res_req;
  logic             nmr_req;
  logic             trg_veto;
  logic             res_veto;
  logic             drop_clr;
  logic             running;
  logic             ctr_out;
  logic             trg_out;
  logic             res_out;
  logic [7:0]       trg_pending;
  logic [CNT_W-1:0] trg_drop_cnt;

  modport master (
    output sync, cal, trg, res_roc, res_tbm, res_req, nmr_req,
           trg_veto, res_veto, drop_clr,
    input  running, ctr_out, trg_out, res_out, trg_pending, trg_drop_cnt
  );

  modport slave (
    input  sync, cal, trg, res_roc, res_tbm, res_req, nmr_req,
           trg_veto, res_veto, drop_clr,
    output running, ctr_out, trg_out, res_out, trg_pending, trg_drop_cnt
  );
endinterface

// File: rtl/ctr_seq_encoder_sym_shifter.sv
// MSB-first symbol shifter with bit counter. Zeros shift in, so the line
// returns to 0 by itself once a symbol has been fully sent.
module ctr_sym_shifter #(
  parameter int SYM_LEN = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               load,
  input  logic               shift,
  input  logic [SYM_LEN-1:0] code,
  output logic               msb,
  output logic               last
);
  localparam int CW = $clog2(SYM_LEN + 1);

  logic [SYM_LEN-1:0] sreg_q;
  logic [CW-1:0]      cnt_q;

  // load wins over shift so a new symbol can start on the final bit tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (en) begin
      if (load) begin
        sreg_q <= code;
        cnt_q  <= '0;
      end else if (shift) begin
        sreg_q <= sreg_q << 1;
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  assign msb  = sreg_q[SYM_LEN-1];
  assign last = (cnt_q == CW'(SYM_LEN - 1));

endmodule

// File: rtl/ctr_seq_encoder.sv
// Serial cal/trg/res command encoder for the ctr line: request capture,
// trigger queue with drop counter, priority dispatch and symbol FSM.
module ctr_seq_encoder
  import ctr_pkg::*;
#(
  parameter int                 SYM_LEN   = DEF_SYM_LEN,
  parameter logic [SYM_LEN-1:0] CODE_CAL  = DEF_CODE_CAL,
  parameter logic [SYM_LEN-1:0] CODE_TRG  = DEF_CODE_TRG,
  parameter logic [SYM_LEN-1:0] CODE_RES  = DEF_CODE_RES,
  parameter logic [SYM_LEN-1:0] CODE_TBM  = DEF_CODE_TBM,
  parameter int                 GAP_LEN   = 0,
  parameter int                 TRG_DEPTH = 4,
  parameter int                 CNT_W     = 16
) (
  input logic               clk,
  input logic               reset_n,
  ctr_seq_encoder_if.slave  bus
);
  localparam logic [7:0] GAP_LAST = 8'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [7:0] DEPTH    = 8'(TRG_DEPTH);

  logic             cal_p, tbm_p, res_p, rreq_p, nmr_p;
  logic [7:0]       pend_q;
  logic [CNT_W-1:0] drop_q;
  state_e           state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic             run_q, trg_o_q, res_o_q;

  logic             res_eff, tbm_eff, trg_eff, cal_eff, any_eff;
  cmd_e             sel;
  logic [SYM_LEN-1:0] code_sel;
  logic             sym_last, sym_bit, free, dispatch;
  logic             clr_res, clr_tbm, clr_trg, clr_cal;
  logic             trg_acc, trg_inc, trg_ovf;

  // effective requests and priority pick (RES > TBM > TRG > CAL)
  always_comb begin
    res_eff  = nmr_p | ((res_p | rreq_p) & ~bus.res_veto);
    tbm_eff  = tbm_p & ~bus.res_veto;
    trg_eff  = (pend_q != 8'd0);
    cal_eff  = cal_p;
    any_eff  = res_eff | tbm_eff | trg_eff | cal_eff;
    sel      = CMD_CAL;
    code_sel = CODE_CAL;
    if (res_eff) begin
      sel      = CMD_RES;
      code_sel = CODE_RES;
    end else if (tbm_eff) begin
      sel      = CMD_TBM;
      code_sel = CODE_TBM;
    end else if (trg_eff) begin
      sel      = CMD_TRG;
      code_sel = CODE_TRG;
    end
  end

  // next state; "free" marks ticks where a new symbol may start, including
  // the tick that ends a symbol (no gap) or ends the gap
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    dispatch = 1'b0;
    free     = 1'b0;
    case (state_q)
      SHIFT: begin
        if (sym_last) begin
          gap_d = 8'd0;
          if (GAP_LEN > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            free    = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          free    = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        free    = 1'b1;
      end
    endcase
    if (free && any_eff) begin
      dispatch = 1'b1;
      state_d  = SHIFT;
    end
  end

  assign clr_res = dispatch && (sel == CMD_RES);
  assign clr_tbm = dispatch && (sel == CMD_TBM);
  assign clr_trg = dispatch && (sel == CMD_TRG);
  assign clr_cal = dispatch && (sel == CMD_CAL);
  assign trg_acc = bus.trg & ~bus.trg_veto;
  assign trg_inc = trg_acc && (pend_q < DEPTH);
  assign trg_ovf = trg_acc && (pend_q >= DEPTH);

  // request flags; a new capture overrides a same-tick dispatch clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cal_p  <= 1'b0;
      tbm_p  <= 1'b0;
      res_p  <= 1'b0;
      rreq_p <= 1'b0;
      nmr_p  <= 1'b0;
    end else if (bus.sync) begin
      cal_p  <= bus.cal | (cal_p & ~clr_cal);
      tbm_p  <= (bus.res_tbm & ~bus.res_veto) | (tbm_p & ~clr_tbm);
      res_p  <= (bus.res_roc & ~bus.res_veto) | (res_p & ~clr_res);
      rreq_p <= bus.res_req | (rreq_p & ~clr_res);
      nmr_p  <= bus.nmr_req | (nmr_p & ~clr_res);
    end
  end

  // trigger queue depth; capture and dispatch on one tick cancel out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pend_q <= 8'd0;
    else if (bus.sync)
      pend_q <= pend_q + 8'(trg_inc) - 8'(clr_trg);
  end

  // saturating overflow counter; clear acts every clk and beats an overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_q <= '0;
    else if (bus.drop_clr)
      drop_q <= '0;
    else if (bus.sync && trg_ovf && (drop_q != {CNT_W{1'b1}}))
      drop_q <= drop_q + CNT_W'(1);
  end

  // FSM state and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gap_q   <= 8'd0;
      run_q   <= 1'b0;
      trg_o_q <= 1'b0;
      res_o_q <= 1'b0;
    end else if (bus.sync) begin
      state_q <= state_d;
      gap_q   <= gap_d;
      run_q   <= (state_d == SHIFT);
      trg_o_q <= clr_trg;
      res_o_q <= clr_res;
    end
  end

  ctr_sym_shifter #(.SYM_LEN(SYM_LEN)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.sync),
    .load    (dispatch),
    .shift   (state_q == SHIFT),
    .code    (code_sel),
    .msb     (sym_bit),
    .last    (sym_last)
  );

  assign bus.ctr_out      = sym_bit;
  assign bus.running      = run_q;
  assign bus.trg_out      = trg_o_q;
  assign bus.res_out      = res_o_q;
  assign bus.trg_pending  = pend_q;
  assign bus.trg_drop_cnt = drop_q;

endmodule

// File: tb/tb_ctr_seq_encoder.sv
// Directed bench for ctr_seq_encoder: default instance (a) and a
// TRG_DEPTH=2 / GAP_LEN=8 instance (b) share clock and reset.
module tb_ctr_seq_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ctr_seq_encoder_if #(.CNT_W(16)) ifa ();
  ctr_seq_encoder_if #(.CNT_W(16)) ifb ();

  ctr_seq_encoder #(.CNT_W(16)) u_a (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (ifa)
  );

  ctr_seq_encoder #(.GAP_LEN(8), .TRG_DEPTH(2), .CNT_W(16)) u_b (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (ifb)
  );

  // one clk; inputs were set on the preceding negedge, sample on the next
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, first, cnt, run_cnt, bad;
    int starts[4];

    rst_n = 1'b0;
    ifa.sync = 1'b1; ifa.cal = 1'b0; ifa.trg = 1'b0; ifa.res_roc = 1'b0;
    ifa.res_tbm = 1'b0; ifa.res_req = 1'b0; ifa.nmr_req = 1'b0;
    ifa.trg_veto = 1'b0; ifa.res_veto = 1'b0; ifa.drop_clr = 1'b0;
    ifb.sync = 1'b1; ifb.cal = 1'b0; ifb.trg = 1'b0; ifb.res_roc = 1'b0;
    ifb.res_tbm = 1'b0; ifb.res_req = 1'b0; ifb.nmr_req = 1'b0;
    ifb.trg_veto = 1'b0; ifb.res_veto = 1'b0; ifb.drop_clr = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ctr", 32'(ifa.ctr_out), 32'd0);
    chk("rst_run", 32'(ifa.running), 32'd0);
    chk("rst_pend", 32'(ifa.trg_pending), 32'd0);
    chk("rst_drop", 32'(ifb.trg_drop_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: cal -> 100 on ticks 1-3
    ifa.cal = 1'b1; step(); ifa.cal = 1'b0;
    chk("t1_run0", 32'(ifa.running), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t1_ctr", 32'(ifa.ctr_out), 32'(k == 1));
      chk("t1_run", 32'(ifa.running), 32'(k <= 3));
      chk("t1_trgo", 32'(ifa.trg_out), 32'd0);
      chk("t1_reso", 32'(ifa.res_out), 32'd0);
    end

    // 2: res_roc + trg -> 111 then 110 back to back
    ifa.res_roc = 1'b1; ifa.trg = 1'b1; step();
    ifa.res_roc = 1'b0; ifa.trg = 1'b0;
    chk("t2_pend1", 32'(ifa.trg_pending), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t2_ctr", 32'(ifa.ctr_out), 32'(k <= 5));
      chk("t2_run", 32'(ifa.running), 32'(k <= 6));
      chk("t2_reso", 32'(ifa.res_out), 32'(k == 1));
      chk("t2_trgo", 32'(ifa.trg_out), 32'(k == 4));
      if (k == 4) chk("t2_pend0", 32'(ifa.trg_pending), 32'd0);
    end

    // 3: depth 2, gap 8, trg on ticks 0-5
    n = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      ifb.trg = (k <= 5);
      step();
      if (ifb.trg_out) begin
        if (n < 4) starts[n] = k;
        n++;
      end
      if (k >= 4 && k <= 11 && (ifb.running || ifb.ctr_out)) bad++;
      if (k == 2) chk("t3_pend2", 32'(ifb.trg_pending), 32'd2);
      if (k == 5) begin
        chk("t3_pend_full", 32'(ifb.trg_pending), 32'd2);
        chk("t3_drop3", 32'(ifb.trg_drop_cnt), 32'd3);
      end
    end
    ifb.trg = 1'b0;
    chk("t3_nsym", 32'(n), 32'd3);
    chk("t3_start0", 32'(starts[0]), 32'd1);
    chk("t3_start1", 32'(starts[1]), 32'd12);
    chk("t3_start2", 32'(starts[2]), 32'd23);
    chk("t3_gap_idle", 32'(bad), 32'd0);
    chk("t3_pend_end", 32'(ifb.trg_pending), 32'd0);
    // clear works even without a sync tick
    ifb.sync = 1'b0; ifb.drop_clr = 1'b1; step();
    ifb.drop_clr = 1'b0; ifb.sync = 1'b1;
    chk("t3_drop_clr", 32'(ifb.trg_drop_cnt), 32'd0);
    // clear and overflow on the same tick -> 0
    for (int k = 0; k <= 4; k++) begin
      ifb.trg = 1'b1;
      ifb.drop_clr = (k == 4);
      step();
      if (k == 3) chk("t3b_drop1", 32'(ifb.trg_drop_cnt), 32'd1);
      if (k == 4) chk("t3b_clr_ovf", 32'(ifb.trg_drop_cnt), 32'd0);
    end
    ifb.trg = 1'b0; ifb.drop_clr = 1'b0;

    // 4a: vetoed resets ignored, held res_req fires when veto drops
    first = -1; run_cnt = 0; bad = 0;
    for (int k = 0; k < 15; k++) begin
      ifa.res_veto = (k <= 9);
      ifa.res_roc  = (k == 0);
      ifa.res_tbm  = (k == 1);
      ifa.res_req  = (k == 2);
      step();
      if (ifa.res_out && first < 0) first = k;
      if (ifa.running) run_cnt++;
      if (ifa.running && k < 10) bad++;
    end
    ifa.res_veto = 1'b0; ifa.res_roc = 1'b0; ifa.res_tbm = 1'b0; ifa.res_req = 1'b0;
    chk("t4a_first", 32'(first), 32'd10);
    chk("t4a_early", 32'(bad), 32'd0);
    chk("t4a_runcnt", 32'(run_cnt), 32'd3);

    // 4b: nmr_req overrides veto and clears the held res_req
    first = -1; cnt = 0; run_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      ifa.res_veto = (k <= 9);
      ifa.res_req  = (k == 2);
      ifa.nmr_req  = (k == 3);
      step();
      if (ifa.res_out) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (ifa.running) run_cnt++;
    end
    ifa.res_veto = 1'b0; ifa.res_req = 1'b0; ifa.nmr_req = 1'b0;
    chk("t4b_first", 32'(first), 32'd4);
    chk("t4b_count", 32'(cnt), 32'd1);
    chk("t4b_runcnt", 32'(run_cnt), 32'd3);

    // 5: async reset during bit 2 of a TRG with 3 pending
    for (int k = 0; k <= 5; k++) begin
      ifa.res_roc = (k == 0);
      ifa.trg     = (k == 0 || k == 1 || k == 2 || k == 4);
      step();
    end
    ifa.res_roc = 1'b0; ifa.trg = 1'b0;
    chk("t5_pre_pend", 32'(ifa.trg_pending), 32'd3);
    chk("t5_pre_ctr", 32'(ifa.ctr_out), 32'd1);
    chk("t5_pre_run", 32'(ifa.running), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ctr", 32'(ifa.ctr_out), 32'd0);
    chk("t5_run", 32'(ifa.running), 32'd0);
    chk("t5_pend", 32'(ifa.trg_pending), 32'd0);
    chk("t5_trgo", 32'(ifa.trg_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ifa.running || ifa.ctr_out) run_cnt++;
    end
    chk("t5_no_resume", 32'(run_cnt), 32'd0);

    // 6: sync low mid-symbol freezes everything
    ifa.cal = 1'b1; step(); ifa.cal = 1'b0;
    step();
    chk("t6_bit1", 32'(ifa.ctr_out), 32'd1);
    ifa.sync = 1'b0;
    for (int j = 0; j < 5; j++) begin
      ifa.cal = j[0];
      ifa.trg = ~j[0];
      step();
      chk("t6_frz_ctr", 32'(ifa.ctr_out), 32'd1);
      chk("t6_frz_run", 32'(ifa.running), 32'd1);
      chk("t6_frz_pend", 32'(ifa.trg_pending), 32'd0);
    end
    ifa.cal = 1'b0; ifa.trg = 1'b0; ifa.sync = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("t6_ctr", 32'(ifa.ctr_out), 32'd0);
      chk("t6_run", 32'(ifa.running), 32'(k <= 3));
    end
    chk("t6_pend", 32'(ifa.trg_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
